// File: rtl/mult_pool_collector.sv
// Collects per-lane multiplier results, tracks lane occupancy and serialises
// results into one output-write stream with partial/full completion flags.
module mult_pool_collector #(
  parameter int Nmult = 64,
  parameter int Mmult = 6,
  parameter int W     = 64,
  parameter int NEED  = 2700,
  parameter int IW    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 issue_valid,
  input  logic [Mmult-1:0]     issue_lane,
  input  logic [IW-1:0]        issue_idx,
  input  logic [Nmult-1:0]     res_valid,
  input  logic [Nmult*W-1:0]   res_data,
  output logic [Nmult-1:0]     mult_loc,
  output logic                 wr_valid,
  output logic [IW-1:0]        wr_idx,
  output logic [W-1:0]         wr_data,
  output logic                 conv_done_partial,
  output logic                 conv_done_full,
  output logic                 err
);

  // Lane state is two flags: neither = IDLE, busy = BUSY, held = HELD.
  logic [Nmult-1:0] busy_q, busy_d, held_q, held_d;
  logic [Nmult-1:0] idle, cap, cand, sel, iss_acc, bad_res;
  logic [IW-1:0]    tag_q  [Nmult];
  logic [W-1:0]     data_q [Nmult];
  logic [IW-1:0]    count_q, count_d;
  logic [Mmult-1:0] sel_lane;
  logic             sel_any;
  logic             issue_ok, issue_bad;
  logic             err_d;
  logic [W-1:0]     wr_data_d;

  assign idle      = ~busy_q & ~held_q;
  assign issue_ok  = issue_valid && idle[issue_lane] && !conv_done_full;
  assign issue_bad = issue_valid && !issue_ok;

  genvar gi;
  generate
    for (gi = 0; gi < Nmult; gi++) begin : g_lane
      assign cap[gi]     = busy_q[gi] & res_valid[gi];
      // A result arriving this cycle competes for the write port immediately.
      assign cand[gi]    = held_q[gi] | cap[gi];
      assign bad_res[gi] = res_valid[gi] & ~busy_q[gi];
      assign iss_acc[gi] = issue_ok && (issue_lane == Mmult'(gi));
      assign sel[gi]     = sel_any && (sel_lane == Mmult'(gi));
      assign busy_d[gi]  = !start && (iss_acc[gi] || (busy_q[gi] && !res_valid[gi]));
      assign held_d[gi]  = !start && (cap[gi] || held_q[gi]) && !sel[gi];
    end
  endgenerate

  always_comb begin
    sel_any  = 1'b0;
    sel_lane = '0;
    for (int i = Nmult - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_any  = 1'b1;
        sel_lane = Mmult'(i);
      end
    end
  end

  assign wr_data_d = held_q[sel_lane] ? data_q[sel_lane] : res_data[sel_lane*W +: W];

  // count saturates at NEED so stray late writes cannot wrap it.
  assign count_d = start ? '0 :
                   (sel_any && count_q != IW'(NEED)) ? count_q + 1'b1 : count_q;

  assign err_d = !start && (err || issue_bad || (|bad_res) || (sel_any && conv_done_full));

  always_ff @(posedge clk) begin
    for (int i = 0; i < Nmult; i++) begin
      if (iss_acc[i]) tag_q[i] <= issue_idx;
      if (cap[i])     data_q[i] <= res_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q            <= '0;
      held_q            <= '0;
      count_q           <= '0;
      mult_loc          <= '0;
      wr_valid          <= 1'b0;
      wr_idx            <= '0;
      wr_data           <= '0;
      conv_done_partial <= 1'b0;
      conv_done_full    <= 1'b0;
      err               <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      held_q   <= held_d;
      count_q  <= count_d;
      mult_loc <= busy_d | held_d;
      wr_valid <= !start && sel_any;
      if (!start && sel_any) begin
        wr_idx  <= tag_q[sel_lane];
        wr_data <= wr_data_d;
      end
      // Flags look back at the write just presented: count_q and mult_loc
      // already reflect it.
      conv_done_partial <= !start && wr_valid && (mult_loc == '0) && (count_q != IW'(NEED));
      conv_done_full    <= !start && (conv_done_full || (wr_valid && count_q == IW'(NEED)));
      err               <= err_d;
    end
  end

endmodule

// File: tb/tb_mult_pool_collector.sv
// Randomised and directed scoreboard bench for mult_pool_collector against a
// lane-level behavioural model.
module tb_mult_pool_collector;
  localparam int N = 64, M = 6, W = 64, NEED = 4, IW = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0, issue_valid = 1'b0;
  logic [M-1:0]   issue_lane = '0;
  logic [IW-1:0]  issue_idx = '0;
  logic [N-1:0]   res_valid = '0;
  logic [N*W-1:0] res_data = '0;
  logic [N-1:0]   mult_loc;
  logic           wr_valid, conv_done_partial, conv_done_full, err;
  logic [IW-1:0]  wr_idx;
  logic [W-1:0]   wr_data;

  mult_pool_collector #(.Nmult(N), .Mmult(M), .W(W), .NEED(NEED), .IW(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .issue_valid(issue_valid),
    .issue_lane(issue_lane), .issue_idx(issue_idx), .res_valid(res_valid),
    .res_data(res_data), .mult_loc(mult_loc), .wr_valid(wr_valid),
    .wr_idx(wr_idx), .wr_data(wr_data), .conv_done_partial(conv_done_partial),
    .conv_done_full(conv_done_full), .err(err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] loc;
    logic wv, part, full, er;
  } stat_t;
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
  } wr_t;

  stat_t stat_q[$];
  wr_t   wr_q[$];
  int    n_chk = 0, n_fail = 0;

  // Behavioural model: lane status 0 idle, 1 awaiting result, 2 holding result.
  int            ms[N];
  logic [IW-1:0] mtag[N];
  logic [W-1:0]  mdat[N];
  int            mcount;
  bit            mfull, merr, prev_wr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) ms[i] = 0;
    mcount = 0; mfull = 0; merr = 0; prev_wr = 0;
  endtask

  task automatic model_step();
    stat_t s;
    wr_t   w;
    int    pick;
    bit    iss_ok, occupied, part, fullset;
    s = '0;
    if (start) begin
      model_clear();
    end else begin
      occupied = 0;
      for (int i = 0; i < N; i++) if (ms[i] != 0) occupied = 1;
      part    = prev_wr && !occupied && mcount < NEED;
      fullset = prev_wr && mcount == NEED;
      iss_ok  = issue_valid && ms[issue_lane] == 0 && !mfull;
      if (issue_valid && !iss_ok) merr = 1;
      for (int i = 0; i < N; i++) begin
        if (res_valid[i] && ms[i] != 1) merr = 1;
        else if (res_valid[i]) begin ms[i] = 2; mdat[i] = res_data[i*W +: W]; end
      end
      pick = -1;
      for (int i = 0; i < N && pick < 0; i++) if (ms[i] == 2) pick = i;
      if (pick >= 0) begin
        w.idx = mtag[pick]; w.data = mdat[pick];
        wr_q.push_back(w);
        ms[pick] = 0;
        if (mcount < NEED) mcount++;
        if (mfull) merr = 1;
      end
      if (iss_ok) begin ms[issue_lane] = 1; mtag[issue_lane] = issue_idx; end
      mfull   = mfull | fullset;
      prev_wr = (pick >= 0);
      s.wv = prev_wr; s.part = part; s.full = mfull;
      for (int i = 0; i < N; i++) s.loc[i] = (ms[i] != 0);
    end
    s.er = merr;
    stat_q.push_back(s);
  endtask

  task automatic cyc(input bit st, input bit iv, input int il, input int ii,
                     input logic [N-1:0] rv, input logic [N*W-1:0] rd);
    @(negedge clk);
    start = st; issue_valid = iv; issue_lane = M'(il); issue_idx = IW'(ii);
    res_valid = rv; res_data = rd;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, '0, '0);
  endtask

  function automatic logic [N-1:0] bit_of(input int l);
    logic [N-1:0] v;
    v = '0; v[l] = 1'b1;
    return v;
  endfunction

  // Monitor: compares one expected status per clock, pops writes when presented.
  initial begin
    stat_t s;
    wr_t   w;
    forever begin
      @(posedge clk); #1;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("mult_loc", mult_loc, s.loc);
        chk("wr_valid", wr_valid, s.wv);
        chk("done_partial", conv_done_partial, s.part);
        chk("done_full", conv_done_full, s.full);
        chk("err", err, s.er);
        if (wr_valid) begin
          if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            w = wr_q.pop_front();
            chk("wr_idx", wr_idx, w.idx);
            chk("wr_data", wr_data, w.data);
          end
        end
      end
    end
  end

  initial begin
    logic [N*W-1:0] rd;
    logic [N-1:0]   rv;
    model_clear();
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", {mult_loc, wr_valid, wr_idx, wr_data, conv_done_partial, conv_done_full, err}, '0);
    @(negedge clk) rst = 1'b0;

    // Single job lane 5, tag 7, result two cycles later.
    cyc(1, 0, 0, 0, '0, '0);
    cyc(0, 1, 5, 7, '0, '0);
    idle(1);
    rd = '0; rd[5*W +: W] = 64'hAB;
    cyc(0, 0, 0, 0, bit_of(5), rd);
    @(posedge clk); #2;
    chk("t1_wr", {wr_valid, wr_idx, wr_data}, {1'b1, 12'd7, 64'hAB});
    idle(3);

    // Simultaneous results on lanes 3, 1, 9: written 1, 3, 9.
    cyc(1, 0, 0, 0, '0, '0);
    cyc(0, 1, 3, 30, '0, '0);
    cyc(0, 1, 1, 10, '0, '0);
    cyc(0, 1, 9, 90, '0, '0);
    for (int l = 0; l < N; l++) rd[l*W +: W] = {$urandom, $urandom};
    cyc(0, 0, 0, 0, bit_of(1) | bit_of(3) | bit_of(9), rd);
    idle(5);

    // Four jobs reach NEED; a fifth issue is an error.
    cyc(1, 0, 0, 0, '0, '0);
    for (int l = 0; l < 4; l++) cyc(0, 1, l, 100 + l, '0, '0);
    cyc(0, 0, 0, 0, 64'hF, rd);
    idle(5);
    cyc(0, 1, 20, 5, '0, '0);
    idle(2);

    // Issue to busy lane 2 and result on idle lane 6.
    cyc(1, 0, 0, 0, '0, '0);
    cyc(0, 1, 2, 1, '0, '0);
    cyc(0, 1, 2, 2, '0, '0);
    cyc(0, 0, 0, 0, bit_of(6), rd);
    idle(2);

    // Re-issue lane 4 in the cycle its write is presented.
    cyc(1, 0, 0, 0, '0, '0);
    cyc(0, 1, 4, 44, '0, '0);
    cyc(0, 0, 0, 0, bit_of(4), rd);
    cyc(0, 1, 4, 45, '0, '0);
    cyc(0, 0, 0, 0, bit_of(4), ~rd);
    idle(3);

    // Start flushes busy lanes; then asynchronous reset mid-cycle.
    cyc(1, 0, 0, 0, '0, '0);
    for (int l = 0; l < 3; l++) cyc(0, 1, l, l, '0, '0);
    cyc(1, 0, 0, 0, '0, '0);
    idle(2);
    for (int l = 0; l < 3; l++) cyc(0, 1, l, l, '0, '0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_reset", {mult_loc, wr_valid, wr_idx, wr_data, conv_done_partial, conv_done_full, err}, '0);
    stat_q.delete(); wr_q.delete();
    model_clear();
    @(negedge clk) rst = 1'b0;

    // Random traffic, restarted at random intervals.
    for (int ph = 0; ph < 40; ph++) begin
      cyc(1, 0, 0, 0, '0, '0);
      for (int k = 0; k < 8 + int'($urandom_range(0, 30)); k++) begin
        rv = '0;
        for (int l = 0; l < 12; l++) if (ms[l] == 1 && $urandom_range(0, 2) == 0) rv[l] = 1'b1;
        if ($urandom_range(0, 60) == 0) rv[$urandom_range(0, 15)] = 1'b1;
        for (int l = 0; l < N; l++) rd[l*W +: W] = {$urandom, $urandom};
        cyc(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
            int'($urandom_range(0, 4095)), rv, rd);
      end
    end
    idle(N + 4);
    @(posedge clk); #2;
    chk("writes_drained", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
